// File: rtl/fifo_uart_tx.sv
// Drains an 8-bit FIFO one byte at a time and serialises each byte as an 8N1 UART frame.
// All outputs are registered; TX is computed from the next state so it never glitches.
module fifo_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 234
) (
    input  logic       CLOCK,
    input  logic       RESET_N,
    input  logic       FIFO_EMPTY,
    input  logic [7:0] FIFO_Q,
    output logic       FIFO_RDEN,
    output logic       TX,
    output logic       BUSY,
    output logic       DONE
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned BIT_W  = 3;
    localparam int unsigned DATA_W = 8;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_LATCH,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t              state, state_next;
    logic [CNT_W-1:0]    baud_cnt, baud_cnt_next;
    logic [BIT_W-1:0]    bit_idx, bit_idx_next;
    logic [DATA_W-1:0]   shift_reg, shift_next;
    logic                tx_next, rden_next, busy_next, done_next;
    logic                bit_end_c;

    // State, datapath and output registers
    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            state     <= S_IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            TX        <= 1'b1;
            FIFO_RDEN <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
        end else begin
            state     <= state_next;
            baud_cnt  <= baud_cnt_next;
            bit_idx   <= bit_idx_next;
            shift_reg <= shift_next;
            TX        <= tx_next;
            FIFO_RDEN <= rden_next;
            BUSY      <= busy_next;
            DONE      <= done_next;
        end
    end

    // Next-state, datapath and next-output logic
    always_comb begin
        state_next    = state;
        baud_cnt_next = '0;
        bit_idx_next  = bit_idx;
        shift_next    = shift_reg;
        tx_next       = 1'b1;
        rden_next     = 1'b0;
        busy_next     = 1'b0;
        done_next     = 1'b0;
        bit_end_c     = (baud_cnt == BAUD_LAST);

        case (state)
            S_IDLE: begin
                if (!FIFO_EMPTY) state_next = S_POP;
            end
            S_POP: begin
                state_next = S_LATCH;
            end
            S_LATCH: begin
                shift_next   = FIFO_Q;
                bit_idx_next = '0;
                state_next   = S_START;
            end
            S_START: begin
                baud_cnt_next = bit_end_c ? '0 : baud_cnt + 1'b1;
                if (bit_end_c) state_next = S_DATA;
            end
            S_DATA: begin
                baud_cnt_next = bit_end_c ? '0 : baud_cnt + 1'b1;
                if (bit_end_c) begin
                    shift_next   = {1'b0, shift_reg[DATA_W-1:1]};
                    bit_idx_next = bit_idx + 1'b1;
                    if (bit_idx == BIT_LAST) state_next = S_STOP;
                end
            end
            S_STOP: begin
                baud_cnt_next = bit_end_c ? '0 : baud_cnt + 1'b1;
                if (bit_end_c) state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Outputs follow the state being entered so they line up with it once registered
        rden_next = (state_next == S_POP);
        busy_next = (state_next != S_IDLE);
        done_next = (state == S_STOP) && (state_next == S_IDLE);
        case (state_next)
            S_START: tx_next = 1'b0;
            S_DATA:  tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench: FIFO model with one-cycle read latency, a UART line decoder and
// event monitors feed a directed sequence of immediate-assertion checks.
module tb_fifo_uart_tx;

    localparam int CPB = 4;
    localparam int BYTE_CYCLES = 10 * CPB + 3;

    logic       CLOCK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       FIFO_EMPTY = 1'b1;
    logic [7:0] FIFO_Q = 8'h00;
    logic       FIFO_RDEN, TX, BUSY, DONE;

    int errors = 0;
    int checks = 0;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .CLOCK      (CLOCK),
        .RESET_N    (RESET_N),
        .FIFO_EMPTY (FIFO_EMPTY),
        .FIFO_Q     (FIFO_Q),
        .FIFO_RDEN  (FIFO_RDEN),
        .TX         (TX),
        .BUSY       (BUSY),
        .DONE       (DONE)
    );

    always #5 CLOCK = ~CLOCK;

    // FIFO model: a read requested in one cycle presents its data in the next
    logic [7:0] fifo_mem[$];
    logic       force_empty = 1'b0;
    always @(negedge CLOCK) begin
        if (FIFO_RDEN === 1'b1 && fifo_mem.size() > 0) FIFO_Q = fifo_mem.pop_front();
        FIFO_EMPTY = force_empty || (fifo_mem.size() == 0);
    end

    // Event monitors
    int   cyc = 0;
    int   rden_cnt = 0, done_cnt = 0, both_hi = 0, rden_double = 0;
    int   rden_cycles[$];
    logic rden_prev = 1'b0;
    always @(negedge CLOCK) begin
        cyc++;
        if (FIFO_RDEN === 1'b1) begin
            rden_cnt++;
            rden_cycles.push_back(cyc);
            if (rden_prev) rden_double++;
        end
        if (DONE === 1'b1) done_cnt++;
        if (DONE === 1'b1 && FIFO_RDEN === 1'b1) both_hi++;
        rden_prev = (FIFO_RDEN === 1'b1);
    end

    // UART line decoder: samples mid-bit, aborts a frame when reset is seen
    logic [7:0] rx_q[$];
    logic [7:0] rx_byte = 8'h00;
    logic       rx_active = 1'b0;
    logic       tx_prev = 1'b1;
    int         rx_t = 0;
    int         rx_bad = 0;
    always @(negedge CLOCK) begin
        if (RESET_N !== 1'b1) begin
            rx_active = 1'b0;
        end else if (!rx_active) begin
            if (tx_prev === 1'b1 && TX === 1'b0) begin
                rx_active = 1'b1;
                rx_t = 0;
            end
        end else begin
            rx_t++;
            if (rx_t >= CPB && rx_t < 9 * CPB && (rx_t % CPB) == CPB / 2)
                rx_byte[rx_t / CPB - 1] = TX;
            if (rx_t == 9 * CPB + CPB / 2) begin
                if (TX === 1'b1) rx_q.push_back(rx_byte);
                else rx_bad++;
                rx_active = 1'b0;
            end
        end
        tx_prev = TX;
    end

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rden(input string tag, input int budget);
        int n = 0;
        while (FIFO_RDEN !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 32'(FIFO_RDEN), 32'd1);
    endtask

    task automatic wait_done(input string tag, input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 32'(done_cnt >= target), 32'd1);
    endtask

    task automatic expect_rx(input string tag, input logic [7:0] exp);
        logic [7:0] got;
        got = 8'hxx;
        if (rx_q.size() > 0) got = rx_q.pop_front();
        chk(tag, 32'(got), 32'(exp));
    endtask

    initial begin
        logic [7:0] b;
        logic       lvl;
        logic [7:0] exp_q[$];
        int         rden0, done0, idx0, tx_low, n_rand;

        // Reset values with a non-empty FIFO
        fifo_mem.push_back(8'h65);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("reset_outputs", 32'({TX, FIFO_RDEN, BUSY, DONE}), 32'b1000);
        end
        RESET_N = 1'b1;
        tick();
        chk("rden_after_reset", 32'(FIFO_RDEN), 32'd1);
        chk("busy_on_pop", 32'(BUSY), 32'd1);

        // Single byte 0x65: latch cycle, then the 40-cycle frame
        tick();
        chk("latch_outputs", 32'({TX, FIFO_RDEN, BUSY}), 32'b101);
        b = 8'h65;
        for (int k = 0; k < 10 * CPB; k++) begin
            tick();
            if (k / CPB == 0) lvl = 1'b0;
            else if (k / CPB == 9) lvl = 1'b1;
            else lvl = b[k / CPB - 1];
            chk("frame_tx", 32'(TX), 32'(lvl));
        end
        chk("busy_in_stop", 32'(BUSY), 32'd1);
        tick();
        chk("done_idle", 32'({DONE, BUSY, TX}), 32'b101);
        tick();
        chk("done_one_cycle", 32'(DONE), 32'd0);
        chk("single_rden_cnt", 32'(rden_cnt), 32'd1);
        chk("single_done_cnt", 32'(done_cnt), 32'd1);
        expect_rx("single_rx", 8'h65);

        // Three back-to-back bytes
        rden0 = rden_cnt; done0 = done_cnt; idx0 = rden_cycles.size();
        fifo_mem.push_back(8'h65);
        fifo_mem.push_back(8'h66);
        fifo_mem.push_back(8'h67);
        wait_done("three_done_timeout", done0 + 3, 4 * BYTE_CYCLES);
        repeat (50) tick();
        chk("three_rden_cnt", 32'(rden_cnt - rden0), 32'd3);
        chk("three_done_cnt", 32'(done_cnt - done0), 32'd3);
        for (int i = 0; i < 2; i++)
            chk("three_rden_gap", 32'(rden_cycles[idx0 + i + 1] - rden_cycles[idx0 + i]),
                32'(BYTE_CYCLES));
        expect_rx("three_rx0", 8'h65);
        expect_rx("three_rx1", 8'h66);
        expect_rx("three_rx2", 8'h67);

        // Empty FIFO: no reads, line stays idle
        rden0 = rden_cnt; tx_low = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (TX !== 1'b1) tx_low++;
        end
        chk("empty_no_rden", 32'(rden_cnt - rden0), 32'd0);
        chk("empty_tx_high", 32'(tx_low), 32'd0);

        // Reset during data bit 3 of 0x66 abandons it; 0x67 follows intact
        rden0 = rden_cnt; done0 = done_cnt;
        fifo_mem.push_back(8'h66);
        fifo_mem.push_back(8'h67);
        wait_rden("midrst_rden_timeout", 20);
        repeat (19) tick();
        chk("midrst_bit3_tx", 32'({TX, BUSY}), 32'b01);
        RESET_N = 1'b0;
        tick();
        RESET_N = 1'b1;
        chk("midrst_outputs", 32'({TX, BUSY, DONE, FIFO_RDEN}), 32'b1000);
        wait_done("midrst_done_timeout", done0 + 1, 2 * BYTE_CYCLES);
        repeat (20) tick();
        chk("midrst_rden_cnt", 32'(rden_cnt - rden0), 32'd2);
        chk("midrst_done_cnt", 32'(done_cnt - done0), 32'd1);
        chk("midrst_rx_count", 32'(rx_q.size()), 32'd1);
        expect_rx("midrst_rx", 8'h67);

        // FIFO_EMPTY rising during POP: the pop completes, then the block idles
        rden0 = rden_cnt; done0 = done_cnt;
        b = 8'($urandom);
        fifo_mem.push_back(b);
        fifo_mem.push_back(~b);
        wait_rden("late_rden_timeout", 20);
        force_empty = 1'b1;
        wait_done("late_done_timeout", done0 + 1, 2 * BYTE_CYCLES);
        repeat (60) tick();
        chk("late_rden_cnt", 32'(rden_cnt - rden0), 32'd1);
        chk("late_busy", 32'({BUSY, TX}), 32'b01);
        chk("late_fifo_left", 32'(fifo_mem.size()), 32'd1);
        expect_rx("late_rx", b);
        force_empty = 1'b0;
        wait_done("late_drain_timeout", done0 + 2, 2 * BYTE_CYCLES);
        expect_rx("late_drain_rx", ~b);

        // Random bytes drained in order
        n_rand = 6; done0 = done_cnt; rden0 = rden_cnt;
        for (int i = 0; i < n_rand; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            fifo_mem.push_back(b);
        end
        wait_done("rand_done_timeout", done0 + n_rand, (n_rand + 1) * BYTE_CYCLES);
        repeat (20) tick();
        chk("rand_rden_cnt", 32'(rden_cnt - rden0), 32'(n_rand));
        for (int i = 0; i < n_rand; i++) expect_rx("rand_rx", exp_q[i]);

        // Global invariants
        chk("done_rden_overlap", 32'(both_hi), 32'd0);
        chk("rden_double_pulse", 32'(rden_double), 32'd0);
        chk("rx_framing", 32'(rx_bad), 32'd0);
        chk("rx_extra_bytes", 32'(rx_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
